// File: rtl/motor_pkg.sv
// Shared definitions for the stepper move scheduler: FSM encoding, speed
// width, coil patterns and the speed-level to step-period mapping.
package motor_pkg;

  localparam int SPD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] COIL_P0 = 4'b0001;
  localparam logic [3:0] COIL_P1 = 4'b0010;
  localparam logic [3:0] COIL_P2 = 4'b0100;
  localparam logic [3:0] COIL_P3 = 4'b1000;

  // Step period in ramp ticks for speed level s: faster levels give shorter gaps.
  function automatic logic [SPD_W-1:0] period(input int unsigned spd_max,
                                              input logic [SPD_W-1:0] s);
    int unsigned p;
    p = spd_max + 32'd1 - 32'(s);
    return SPD_W'(p);
  endfunction

endpackage

// File: rtl/step_phase_seq.sv
// Four-phase coil sequencer: walks a 2-bit phase index one position per step
// in the commanded direction and decodes it to the one-hot coil pattern.
module step_phase_seq
  import motor_pkg::*;
#(
  parameter bit HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir,
  input  logic       step_en,
  input  logic       busy,
  output logic [3:0] step_ctr
);

  logic [1:0] idx;
  logic [3:0] pat;

  // Phase index advances or retreats once per step; kept across moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 2'd0;
    end else if (step_en) begin
      idx <= dir ? (idx + 2'd1) : (idx - 2'd1);
    end
  end

  // Decode index to coil pattern; de-energise when idle unless holding.
  always_comb begin
    pat = COIL_P0;
    case (idx)
      2'd0: pat = COIL_P0;
      2'd1: pat = COIL_P1;
      2'd2: pat = COIL_P2;
      2'd3: pat = COIL_P3;
      default: pat = COIL_P0;
    endcase
    step_ctr = (busy || HOLD) ? pat : 4'b0000;
  end

endmodule

// File: rtl/step_move_sched.sv
// Counted, ramped, abortable move scheduler for a 4-phase stepper. A command
// (steps, direction, target speed) is accepted in IDLE; steps are timed from a
// prescaled tick and the speed level ramps per step in a trapezoid.
module step_move_sched
  import motor_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int STEP_W   = 16,
  parameter int SPD_MAX  = 15,
  parameter bit HOLD     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic [SPD_W-1:0]  cmd_speed,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              step_pulse,
  output logic [SPD_W-1:0]  cur_speed,
  output logic [3:0]        step_ctr
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t             state, state_nx;
  logic [PW-1:0]      pre_cnt;
  logic [SPD_W-1:0]   timer;
  logic [SPD_W-1:0]   target;
  logic [STEP_W-1:0]  rem;
  logic [STEP_W-1:0]  rem_dec;
  logic               dir_q;
  logic               accept;
  logic               tick;
  logic               step_evt;
  logic [SPD_W-1:0]   spd_nx;
  logic               fin;

  // Saturate a requested speed level into 1..SPD_MAX.
  function automatic logic [SPD_W-1:0] clamp_speed(input logic [SPD_W-1:0] s);
    if (s == '0) return SPD_W'(1);
    else if (int'(s) > SPD_MAX) return SPD_W'(SPD_MAX);
    else return s;
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN) || (state == ST_DECEL);
  assign done      = (state == ST_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (pre_cnt == PW'(TICK_DIV - 1));
  // The step fires on the tick that would take the timer from 1 to 0.
  assign step_evt  = busy && tick && (timer == SPD_W'(1));
  assign rem_dec   = rem - STEP_W'(1);

  // Ramp decision for the step being emitted this cycle (valid while step_pulse).
  always_comb begin
    spd_nx = cur_speed;
    fin    = 1'b0;
    if (state == ST_DECEL) begin
      if ((rem_dec == '0) || (cur_speed <= SPD_W'(1))) fin = 1'b1;
      else spd_nx = cur_speed - SPD_W'(1);
    end else if (rem_dec == '0) begin
      fin = 1'b1;
    end else if (rem_dec <= (STEP_W'(cur_speed) - STEP_W'(1))) begin
      // Braking distance reached: slow down so the last step lands at level 1.
      spd_nx = (cur_speed > SPD_W'(1)) ? (cur_speed - SPD_W'(1)) : cur_speed;
    end else if (cur_speed < target) begin
      spd_nx = cur_speed + SPD_W'(1);
    end else if (cur_speed > target) begin
      spd_nx = cur_speed - SPD_W'(1);
    end
  end

  // Next-state logic for the move FSM.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = (cmd_steps == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (step_pulse && fin) state_nx = ST_DONE;
        else if (abort)        state_nx = ST_DECEL;
      end
      ST_DECEL: begin
        if (step_pulse && fin) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Control outputs: step strobe and the published speed level.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_pulse <= 1'b0;
      cur_speed  <= '0;
    end else begin
      step_pulse <= step_evt;
      if (accept && (cmd_steps != '0)) begin
        cur_speed <= SPD_W'(1);
      end else if (busy && step_pulse) begin
        cur_speed <= fin ? '0 : spd_nx;
      end
    end
  end

  // Move datapath: command latch, prescaler, step timer and remaining count.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem     <= cmd_steps;
      dir_q   <= cmd_dir;
      target  <= clamp_speed(cmd_speed);
      pre_cnt <= '0;
      timer   <= period(SPD_MAX, SPD_W'(1));
    end else if (busy) begin
      pre_cnt <= tick ? '0 : (pre_cnt + PW'(1));
      if (step_pulse) begin
        rem   <= rem_dec;
        timer <= period(SPD_MAX, spd_nx);
      end else if (tick) begin
        timer <= timer - SPD_W'(1);
      end
    end
  end

  step_phase_seq #(
    .HOLD(HOLD)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .dir      (dir_q),
    .step_en  (step_evt),
    .busy     (busy),
    .step_ctr (step_ctr)
  );

endmodule

// File: doc/step_move_sched.md
Name: step_move_sched

Overview:
- Move scheduler for the 4-phase stepper path.
- Accepts a move command (step count, direction, target speed) over a valid/ready handshake.
- Runs the move with a per-step trapezoidal ramp from a prescaled time base, and drives the coil pattern directly.
- Replaces free-running start/stop/speed control with counted, ramped, abortable moves; sits between the key/command logic and the motor coil pins.

Parameters:
- TICK_DIV, 50000: clk cycles per ramp tick (1 kHz at 50 MHz).
- STEP_W, 16: width of the step count.
- SPD_MAX, 15: highest speed level. Step period at level s is (SPD_MAX+1-s) ticks.
- HOLD, 0: 1 = keep the coil energised when idle; 0 = coil output 4'b0000 when idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  move command valid.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_steps  in  STEP_W  number of steps to move.
- cmd_dir  in  1  direction: 1 = forward, 0 = reverse.
- cmd_speed  in  4  target speed level, range 1..SPD_MAX.
- abort  in  1  request a ramped stop.
- busy  out  1  a move is in progress.
- done  out  1  one-cycle pulse at the end of a move.
- step_pulse  out  1  one-cycle pulse per step.
- cur_speed  out  4  current speed level (0 when idle).
- step_ctr  out  4  coil drive pattern.

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, step_pulse=0, cur_speed=0, phase index=0.
  - step_ctr=4'b0000 when HOLD=0; 4'b0001 when HOLD=1.
- Reset mid-move: the move is dropped, no done pulse is issued, and all outputs take their reset values on the next cycle.
- Handshake: a command is accepted on any cycle where cmd_valid and cmd_ready are both 1. cmd_ready is 1 only in IDLE.
- On accept, latch steps, dir and target. A target of 0 is clamped to 1; a target above SPD_MAX is clamped to SPD_MAX.
- FSM states: IDLE, RUN, DECEL, DONE.
- IDLE:
  - Accept with cmd_steps=0 -> DONE (no steps issued).
  - Accept with cmd_steps>0 -> RUN with cur_speed=1; the prescaler and step timer restart, timer = period(1).
- Timing:
  - The prescaler emits a tick every TICK_DIV clk.
  - The step timer decrements on each tick.
  - On the tick that takes the timer to 0, step_pulse is asserted on the next clk cycle, and the phase advances on that same cycle.
- Ramp rule, evaluated per emitted step (r = remaining steps after this step, c = cur_speed):
  - r==0 -> DONE.
  - else if r <= c-1 -> c = c-1 (floor 1).
  - else if c < target -> c+1.
  - else if c > target -> c-1.
  - else c is unchanged.
  - The timer is reloaded with period(new c).
- Abort:
  - In RUN -> DECEL. In DECEL, each step gives c = c-1.
  - A step emitted at c==1 leads to DONE, as does r==0, whichever comes first.
  - Abort in IDLE, DECEL or DONE is ignored.
  - cmd_valid and abort together in IDLE: the command is accepted and the abort is ignored.
- DONE: done=1 for exactly one cycle, busy drops to 0 in the same cycle, cur_speed=0; next state is IDLE.
- busy=1 in RUN and DECEL only.
- Phase sequencer:
  - Index 0..3 maps to patterns 0001, 0010, 0100, 1000.
  - On step_pulse the index changes by +1 mod 4 (dir=1) or -1 mod 4 (dir=0).
  - The index is retained across moves; only reset clears it.
  - step_ctr shows the pattern while busy, or always when HOLD=1; otherwise it is 0000.
- Remaining-step counter: STEP_W bits. It never underflows, because DONE is entered at r==0.

Decomposition:
- Shared package motor_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_RUN, ST_DECEL, ST_DONE);
  - SPD_W=4;
  - the four coil pattern constants;
  - the period function (SPD_MAX+1-s).
- One sub-module: step_phase_seq (dir, step_pulse, index register, pattern decode, HOLD gating).
- Prescaler, timer, ramp logic and FSM stay in step_move_sched.

Test Plan (TICK_DIV=4, SPD_MAX=15, HOLD=0):
- Reset, then idle 20 cycles -> cmd_ready=1, busy=0, step_ctr=0000, no step_pulse.
- Move steps=5, dir=1, speed=15 -> pulses at levels 1,2,3,2,1.
  - Gaps of 15,14,13,14,15 ticks (x4 clk); 71 ticks from accept to last step.
  - step_ctr runs 0010, 0100, 1000, 0001, 0010.
  - done pulses once; cmd_ready stays 0 throughout.
- Move steps=0 -> done two cycles after accept, zero step_pulse, phase index unchanged.
- Move steps=100, speed=3:
  - levels 1,2,3, then cruise at 3, then 2,1 on the final two steps;
  - then a reverse move of 4 steps -> the phase walks backward from the retained index.
- Move steps=1000, speed=15; pulse abort when cur_speed=6 -> DECEL through levels 5,4,3,2,1, then done; total steps well below 1000.
- Move in progress, assert rst for 1 cycle -> next cycle all outputs at reset values, no done; a new command is accepted immediately.
